// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_control
// Description : Moore-style main controller for a multi-cycle MIPS-like
//               datapath. Sequences FETCH/DECODE/execute/writeback states,
//               drives datapath selects and write strobes, and optionally
//               stretches FETCH and MEMREAD for slow memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_WAIT    extra stall cycles in FETCH and MEMREAD (legal 0-7)
// Ports:
//   clk         in   1  single clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   op          in   6  instruction opcode
//   Funct       in   6  R-type function field
//   zero        in   1  ALU zero flag
//   ALUSrcA     out  1  ALU operand A select
//   ALUSrcB     out  2  ALU operand B select
//   ALUControl  out  3  ALU operation
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc, PC_enable
//               out  1  datapath strobes/selects
//   state_disp  out  4  current state code for monitor displays
// Configuration macro:
//   ILLEGAL_OP_TRAP_EN  when defined, illegal opcode/Funct locks the FSM in
//                       TRAP until reset; otherwise it returns to FETCH.
// ============================================================================
module multi_cycle_control #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] Funct,
  input  logic       zero,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCSrc,
  output logic       PC_enable,
  output logic [3:0] state_disp
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;

  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam state_t C_ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_t C_ILLEGAL_NEXT = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic       wait_done;
  logic [2:0] funct_alu;
  logic       funct_ok;

  // --------------------------------------------------------------------------
  // Memory stall counter. With MEM_WAIT=0 no counter exists at all and every
  // FETCH/MEMREAD completes in its first cycle.
  // --------------------------------------------------------------------------
  generate
    if (MEM_WAIT == 0) begin : g_no_wait
      assign wait_done = 1'b1;
    end else begin : g_wait
      localparam logic [2:0] C_WAIT = 3'(MEM_WAIT);
      logic [2:0] wait_q, wait_d;

      assign wait_done = (wait_q == C_WAIT);

      // Count only while stalling in place; any state change clears it, and
      // the count saturates rather than wrapping.
      always_comb begin
        wait_d = 3'd0;
        if ((state_q == S_FETCH || state_q == S_MEMREAD) &&
            (state_d == state_q) && (wait_q != 3'd7)) begin
          wait_d = wait_q + 3'd1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wait_q <= 3'd0;
        end else begin
          wait_q <= wait_d;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Funct decode. The result is latched in DECODE so EXECUTE is immune to
  // Funct changing after the instruction has been decoded.
  // --------------------------------------------------------------------------
  always_comb begin
    funct_alu = C_ALU_ADD;
    funct_ok  = 1'b1;
    case (Funct)
      6'b100000: funct_alu = C_ALU_ADD;
      6'b100010: funct_alu = C_ALU_SUB;
      6'b100100: funct_alu = C_ALU_AND;
      6'b100101: funct_alu = C_ALU_OR;
      6'b101010: funct_alu = C_ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign alu_ctrl_d = (state_q == S_DECODE) ? funct_alu : alu_ctrl_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      alu_ctrl_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      alu_ctrl_q <= alu_ctrl_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (wait_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          C_OP_RTYPE: state_d = funct_ok ? S_EXECUTE : C_ILLEGAL_NEXT;
          C_OP_LW,
          C_OP_SW:    state_d = S_MEMADR;
          C_OP_BEQ:   state_d = S_BRANCH;
          C_OP_ADDI:  state_d = S_ADDIEXEC;
          default:    state_d = C_ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_d = (op == C_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (wait_done) state_d = S_MEMWB;
      end
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH:   state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`else
      S_TRAP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore, except PC_enable follows zero in BRANCH)
  // --------------------------------------------------------------------------
  always_comb begin
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCSrc      = 1'b0;
    PC_enable  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = C_ALU_ADD;
        IRWrite    = wait_done;
        PC_enable  = wait_done;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = C_ALU_ADD;
      end
      S_MEMADR,
      S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = C_ALU_ADD;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_ctrl_q;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = C_ALU_SUB;
        PCSrc      = 1'b1;
        PC_enable  = zero;
      end
      default: begin
      end
    endcase

    // Write strobes must be quiet the instant reset asserts, even though the
    // reset state (FETCH) would otherwise fire IRWrite/PC_enable.
    if (!reset) begin
      PC_enable = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
    end
  end

  assign state_disp = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_control
// Description : Self-checking bench for multi_cycle_control. Runs a table of
//               per-cycle vectors on a MEM_WAIT=0 instance, a second table on
//               a MEM_WAIT=2 instance, plus hand sequences for reset and
//               illegal-instruction handling. Honours ILLEGAL_OP_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  // MEM_WAIT = 0 instance outputs
  logic       a_srca, a_iord, a_mw, a_irw, a_rd, a_mtr, a_rw, a_pcs, a_pce;
  logic [1:0] a_srcb;
  logic [2:0] a_alu;
  logic [3:0] a_st;
  // MEM_WAIT = 2 instance outputs
  logic       w_srca, w_iord, w_mw, w_irw, w_rd, w_mtr, w_rw, w_pcs, w_pce;
  logic [1:0] w_srcb;
  logic [2:0] w_alu;
  logic [3:0] w_st;

  logic [17:0] obs_a, obs_w;
  assign obs_a = {a_st, a_srca, a_srcb, a_alu, a_iord, a_mw, a_irw, a_rd, a_mtr, a_rw, a_pcs, a_pce};
  assign obs_w = {w_st, w_srca, w_srcb, w_alu, w_iord, w_mw, w_irw, w_rd, w_mtr, w_rw, w_pcs, w_pce};

  multi_cycle_control #(.MEM_WAIT(0)) dut (
    .clk(clk), .reset(reset), .op(op), .Funct(funct), .zero(zero),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALUControl(a_alu),
    .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw), .RegDst(a_rd),
    .MemtoReg(a_mtr), .RegWrite(a_rw), .PCSrc(a_pcs), .PC_enable(a_pce),
    .state_disp(a_st)
  );

  multi_cycle_control #(.MEM_WAIT(2)) dut_w (
    .clk(clk), .reset(reset), .op(op), .Funct(funct), .zero(zero),
    .ALUSrcA(w_srca), .ALUSrcB(w_srcb), .ALUControl(w_alu),
    .IorD(w_iord), .MemWrite(w_mw), .IRWrite(w_irw), .RegDst(w_rd),
    .MemtoReg(w_mtr), .RegWrite(w_rw), .PCSrc(w_pcs), .PC_enable(w_pce),
    .state_disp(w_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output words: {state, ALUSrcA, ALUSrcB, ALUControl,
  //   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc, PC_enable}
  localparam logic [17:0] E_FETCH   = {4'd0, 1'b0, 2'b01, 3'b010, 8'b0010_0001};
  localparam logic [17:0] E_FSTALL  = {4'd0, 1'b0, 2'b01, 3'b010, 8'b0000_0000};
  localparam logic [17:0] E_DECODE  = {4'd1, 1'b0, 2'b11, 3'b010, 8'b0000_0000};
  localparam logic [17:0] E_MEMADR  = {4'd2, 1'b1, 2'b10, 3'b010, 8'b0000_0000};
  localparam logic [17:0] E_MEMREAD = {4'd3, 6'b0, 8'b1000_0000};
  localparam logic [17:0] E_MEMWB   = {4'd4, 6'b0, 8'b0000_1100};
  localparam logic [17:0] E_MEMWR   = {4'd5, 6'b0, 8'b1100_0000};
  localparam logic [17:0] E_ALUWB   = {4'd7, 6'b0, 8'b0001_0100};
  localparam logic [17:0] E_ADDIEX  = {4'd9, 1'b1, 2'b10, 3'b010, 8'b0000_0000};
  localparam logic [17:0] E_ADDIWB  = {4'd10, 6'b0, 8'b0000_0100};
  localparam logic [17:0] E_TRAP    = {4'd11, 14'b0};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

  function automatic logic [17:0] e_exec(input logic [2:0] alu);
    return {4'd6, 1'b1, 2'b00, alu, 8'b0000_0000};
  endfunction

  function automatic logic [17:0] e_branch(input logic z);
    return {4'd8, 1'b1, 2'b00, 3'b110, 7'b000_0001, z};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [17:0] exp;
  } vec_t;

  vec_t q_a[$];
  vec_t q_w[$];

  int total = 0;
  int bad   = 0;
  int mw_cycles;

  task automatic check(input string nm, input int idx, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got state=%0d outs=%05h, want state=%0d outs=%05h",
               nm, idx, act[17:14], act, exp[17:14], exp);
    end
  endtask

  task automatic add_a(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [17:0] e);
    q_a.push_back('{o, f, z, e});
  endtask

  task automatic add_w(input logic [5:0] o, input logic [5:0] f, input logic z, input logic [17:0] e);
    q_w.push_back('{o, f, z, e});
  endtask

  // Entered and left one time unit after a rising edge; both DUTs end in FETCH.
  task automatic reset_pulse();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic illegal_seq(input string nm, input logic [5:0] o, input logic [5:0] f);
    reset_pulse();
    op = o; funct = f; zero = 1'b0;
    #1; check({nm, "_fetch"}, 0, obs_a, E_FETCH);
    step(); check({nm, "_decode"}, 1, obs_a, E_DECODE);
    step();
`ifdef ILLEGAL_OP_TRAP_EN
    check({nm, "_trap"}, 2, obs_a, E_TRAP);
    op = OP_LW; funct = 6'b100000;
    for (int k = 0; k < 3; k++) begin
      step(); check({nm, "_trap_hold"}, 3 + k, obs_a, E_TRAP);
    end
`else
    // back to FETCH with no register/memory write in the abandoned path
    check({nm, "_to_fetch"}, 2, obs_a, E_FETCH);
    step(); check({nm, "_redecode"}, 3, obs_a, E_DECODE);
`endif
  endtask

  logic [5:0] r_funct [5];
  logic [2:0] r_alu   [5];

  initial begin
    reset = 1'b0;
    op    = OP_LW;
    funct = 6'b0;
    zero  = 1'b0;

    // ---- table for MEM_WAIT=0 ----
    r_funct = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
    r_alu   = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111};

    // lw: 5 cycles; opcode noise outside DECODE/MEMADR must not matter
    add_a(OP_LW, 6'd0, 1'b0, E_FETCH);
    add_a(OP_LW, 6'd0, 1'b0, E_DECODE);
    add_a(OP_LW, 6'd0, 1'b0, E_MEMADR);
    add_a(OP_BAD, OP_BAD, 1'b0, E_MEMREAD);
    add_a(OP_BEQ, 6'd0, 1'b1, E_MEMWB);
    // sw: 4 cycles
    add_a(OP_SW, 6'd0, 1'b0, E_FETCH);
    add_a(OP_SW, 6'd0, 1'b0, E_DECODE);
    add_a(OP_SW, 6'd0, 1'b0, E_MEMADR);
    add_a(OP_LW, 6'd0, 1'b0, E_MEMWR);
    // R-type: 4 cycles each; Funct changes in EXECUTE must not matter
    for (int i = 0; i < 5; i++) begin
      add_a(OP_R, r_funct[i], 1'b0, E_FETCH);
      add_a(OP_R, r_funct[i], 1'b0, E_DECODE);
      add_a(OP_BAD, OP_BAD, 1'b0, e_exec(r_alu[i]));
      add_a(OP_R, r_funct[i], 1'b0, E_ALUWB);
    end
    // addi: 4 cycles
    add_a(OP_ADDI, 6'd0, 1'b0, E_FETCH);
    add_a(OP_ADDI, 6'd0, 1'b0, E_DECODE);
    add_a(OP_ADDI, 6'd0, 1'b0, E_ADDIEX);
    add_a(OP_ADDI, 6'd0, 1'b0, E_ADDIWB);
    // beq taken then not taken: 3 cycles each
    add_a(OP_BEQ, 6'd0, 1'b0, E_FETCH);
    add_a(OP_BEQ, 6'd0, 1'b0, E_DECODE);
    add_a(OP_BEQ, 6'd0, 1'b1, e_branch(1'b1));
    add_a(OP_BEQ, 6'd0, 1'b1, E_FETCH);
    add_a(OP_BEQ, 6'd0, 1'b1, E_DECODE);
    add_a(OP_BEQ, 6'd0, 1'b0, e_branch(1'b0));
    add_a(OP_LW, 6'd0, 1'b0, E_FETCH);

    // ---- table for MEM_WAIT=2 ----
    add_w(OP_SW, 6'd0, 1'b0, E_FSTALL);
    add_w(OP_SW, 6'd0, 1'b0, E_FSTALL);
    add_w(OP_SW, 6'd0, 1'b0, E_FETCH);
    add_w(OP_SW, 6'd0, 1'b0, E_DECODE);
    add_w(OP_SW, 6'd0, 1'b0, E_MEMADR);
    add_w(OP_SW, 6'd0, 1'b0, E_MEMWR);
    add_w(OP_LW, 6'd0, 1'b0, E_FSTALL);
    add_w(OP_LW, 6'd0, 1'b0, E_FSTALL);
    add_w(OP_LW, 6'd0, 1'b0, E_FETCH);
    add_w(OP_LW, 6'd0, 1'b0, E_DECODE);
    add_w(OP_LW, 6'd0, 1'b0, E_MEMADR);
    add_w(OP_LW, 6'd0, 1'b0, E_MEMREAD);
    add_w(OP_LW, 6'd0, 1'b0, E_MEMREAD);
    add_w(OP_LW, 6'd0, 1'b0, E_MEMREAD);
    add_w(OP_LW, 6'd0, 1'b0, E_MEMWB);
    add_w(OP_LW, 6'd0, 1'b0, E_FSTALL);

    // ---- reset state: FETCH, write strobes held low ----
    step();
    check("reset_a", 0, obs_a, E_FSTALL);
    check("reset_w", 0, obs_w, E_FSTALL);
    step();
    check("reset_a", 1, obs_a, E_FSTALL);
    check("reset_w", 1, obs_w, E_FSTALL);
    reset = 1'b1;

    // ---- MEM_WAIT=0 table ----
    foreach (q_a[i]) begin
      op = q_a[i].op; funct = q_a[i].funct; zero = q_a[i].zero;
      #1;
      check("vec_w0", i, obs_a, q_a[i].exp);
      step();
    end

    // ---- MEM_WAIT=2 table, counting MemWrite cycles ----
    reset_pulse();
    mw_cycles = 0;
    foreach (q_w[i]) begin
      op = q_w[i].op; funct = q_w[i].funct; zero = q_w[i].zero;
      #1;
      check("vec_w2", i, obs_w, q_w[i].exp);
      if (w_mw) mw_cycles++;
      step();
    end
    check("w2_memwrite_cycles", 0, 18'(mw_cycles), 18'd1);

    // ---- reset asserted during MEMWRITE ----
    reset_pulse();
    op = OP_SW; funct = 6'd0; zero = 1'b0;
    step(); step(); step();
    check("rst_mid_memwr", 0, obs_a, E_MEMWR);
    #2 reset = 1'b0;
    #1 check("rst_mid_async", 1, obs_a, E_FSTALL);
    #2 reset = 1'b1;
    #1 check("rst_mid_release", 2, obs_a, E_FETCH);
    step();
    check("rst_mid_decode", 3, obs_a, E_DECODE);

    // ---- illegal funct / illegal opcode ----
    illegal_seq("bad_funct", OP_R, 6'b111111);
    illegal_seq("bad_op", OP_BAD, 6'b100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: simulation exceeded time limit, total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
